spi_slave_ip: RTL
=================

# spi_slave_ip

SPI responder (slave) that sits on the far end of the team's SPI master link. It oversamples the external `sclk_i`, `ss_n_i` and `mosi_i` on the system clock and drives `miso_o`, exchanging full-duplex 8-bit frames MSB-first in any of the four CPOL/CPHA modes. A one-entry transmit buffer lets the host queue the next response byte while a frame is in flight. The block supports back-to-back frames while `ss_n_i` stays low.

## Interface
- No parameters; frame width fixed at 8 bits, MSB first.
- `clk_i` input 1: system clock; all logic on rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `cpol_i` input 1: SCLK idle level; latched at frame start.
- `cpha_i` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start.
- `tx_data_i` input 8: next response byte.
- `tx_load_i` input 1: single-cycle strobe; writes `tx_data_i` into the transmit buffer.
- `tx_ready_o` output 1: transmit buffer empty.
- `dout_o` output 8: last completely received byte.
- `spi_done_tick_o` output 1: one-cycle pulse when a byte completes; `dout_o` is valid in the same cycle.
- `underrun_tick_o` output 1: one-cycle pulse when the shifter loads from an empty buffer.
- `busy_o` output 1: slave selected (synchronized `ss_n` low).
- `sclk_i` input 1: SPI clock from the master (asynchronous).
- `ss_n_i` input 1: active-low slave select (asynchronous).
- `mosi_i` input 1: master-out data (asynchronous).
- `miso_o` output 1: slave-out data; 0 when deselected.

## Operation
- Synchronization:
  - `sclk_i`, `ss_n_i` and `mosi_i` each pass through a 2-flop synchronizer.
  - A third register on sclk and ss_n provides edge detection.
- Edge definitions, using the latched cpol:
  - Leading edge = synced sclk leaving the cpol level.
  - Trailing edge = synced sclk returning to the cpol level.
- FSM states: ST_IDLE, ST_ACTIVE.
  - ST_IDLE → ST_ACTIVE on a synced ss_n falling edge. Actions: latch cpol/cpha, clear bit counter n (3 bits). If cpha=0, load the shifter from the buffer.
  - ST_ACTIVE → ST_IDLE on a synced ss_n rising edge, from any bit position.
- Sample edge (leading if cpha=0, trailing if cpha=1):
  - rx_reg ← {rx_reg[6:0], mosi_sync}; n ← n+1 (wraps 7→0).
  - When n==7 before the increment: `dout_o` ← {rx_reg[6:0], mosi_sync} and `spi_done_tick_o` = 1.
- Shift edge (trailing if cpha=0, leading if cpha=1):
  - If n==0: load the shifter from the buffer (byte boundary).
  - Otherwise: tx_reg ← {tx_reg[6:0], 1'b0}.
- `miso_o` = tx_reg[7] while ST_ACTIVE, else 0.
- Shifter load rules:
  - A load takes the buffer contents and clears the buffer-full flag.
  - If the buffer is empty, the shifter loads 0x00 and `underrun_tick_o` pulses.
- Transmit buffer writes:
  - `tx_load_i` sets the full flag and overwrites the buffer, including when already full; the last write wins.
  - Load and consume in the same cycle: the shifter gets the old contents, and the buffer holds the new byte with full=1.
- Abort: ss_n rises with fewer than 8 sample edges in the current byte.
  - No done tick; `dout_o` unchanged.
  - Partial rx data discarded; n cleared.
  - The transmit buffer is untouched. A byte already moved into the shifter is lost.
- cpol/cpha changes while `busy_o`=1 are ignored until the next frame.

## Timing
- Reset values:
  - `dout_o`=0x00, `spi_done_tick_o`=0, `underrun_tick_o`=0, `busy_o`=0, `miso_o`=0, `tx_ready_o`=1.
  - State ST_IDLE, n=0, tx_reg=rx_reg=0, buffer empty.
- Input-to-action latency: 3 clk_i cycles from a pin edge to its detected action. `miso_o` updates 3 cycles after the pin shift edge.
- Master constraints:
  - Each SCLK phase lasts ≥4 clk_i cycles. With the team master, `dvsr_i` ≥ 3.
  - First SCLK edge comes ≥4 clk_i cycles after ss_n falls.
  - For cpha=0, the master must not sample bit 7 before 4 cycles after ss_n falls.
- `spi_done_tick_o` fires 3 cycles after the 8th sample edge at the pins.
- `tx_ready_o` rises the cycle after a load into the shifter and falls the cycle after `tx_load_i`.
- Reset asserted mid-frame: immediate return to reset values. A later frame starts only on a fresh ss_n falling edge.

## Test plan
- Mode 0, buffer 0x3C, master sends 0xA5 → `dout_o`=0xA5 with one done tick; master receives 0x3C; `tx_ready_o` rises at frame start.
- Mode 3 (cpol=1, cpha=1), buffer 0x81, master sends 0x7E → `dout_o`=0x7E, master receives 0x81; `sclk_o` idles high.
- Back-to-back: buffer 0x11, reload 0x22 during the first byte, ss_n held low for 16 bits, master sends 0xC3, 0x5A → two done ticks with `dout_o` 0xC3 then 0x5A; master receives 0x11, 0x22.
- Underrun: no load before the frame → master receives 0x00; `underrun_tick_o` pulses once.
- Abort: ss_n deasserted after 5 bits → no done tick, `dout_o` keeps its previous value; the next full frame 0x96 is received correctly.
- `tx_load_i` (0x55) in the same cycle as a byte-boundary load of 0xAA → master gets 0xAA now; `tx_ready_o`=0 with 0x55 pending; next byte is 0x55.

Source files
------------

// File: rtl/spi_slave_ip.sv
// SPI responder: oversamples sclk/ss_n/mosi on clk_i, exchanges 8-bit MSB-first
// frames in any CPOL/CPHA mode, with a one-entry transmit buffer ahead of the shifter.
module spi_slave_ip (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic [7:0] dout_o,
  output logic       spi_done_tick_o,
  output logic       underrun_tick_o,
  output logic       busy_o,
  input  logic       sclk_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_sclk_sync;
  logic [2:0]  r_ss_sync;
  logic [1:0]  r_mosi_sync;

  logic        r_cpol;
  logic        r_cpha;
  logic [2:0]  r_n;
  logic [7:0]  r_rx;
  logic [7:0]  r_tx;
  logic [7:0]  r_dout;
  logic        r_done;
  logic        r_under;
  logic [7:0]  r_buf;
  logic        r_full;

  logic        w_sclk;
  logic        w_sclk_d;
  logic        w_ss_fall;
  logic        w_ss_rise;
  logic        w_lead;
  logic        w_trail;
  logic        w_start;
  logic        w_stop;
  logic        w_sample;
  logic        w_shift;
  logic        w_load;

  // ss_n chain resets low so a select held low through reset never looks like a fresh falling edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk_i};
      r_ss_sync   <= {r_ss_sync[1:0], ss_n_i};
      r_mosi_sync <= {r_mosi_sync[0], mosi_i};
    end
  end

  assign w_sclk    = r_sclk_sync[1];
  assign w_sclk_d  = r_sclk_sync[2];
  assign w_ss_fall = ~r_ss_sync[1] & r_ss_sync[2];
  assign w_ss_rise = r_ss_sync[1] & ~r_ss_sync[2];
  assign w_lead    = (w_sclk != r_cpol) && (w_sclk_d == r_cpol);
  assign w_trail   = (w_sclk == r_cpol) && (w_sclk_d != r_cpol);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    w_sample     = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ss_fall) begin
          w_state_next = ST_ACTIVE;
          w_start      = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_ss_rise) begin
          w_state_next = ST_IDLE;
          w_stop       = 1'b1;
        end else begin
          w_sample = r_cpha ? w_trail : w_lead;
          w_shift  = r_cpha ? w_lead  : w_trail;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // the shifter reloads at frame start (cpha=0) or on the first shift edge of each byte
  assign w_load = (w_start & ~cpha_i) | (w_shift & (r_n == 3'd0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_n     <= '0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_under <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_under <= 1'b0;
      if (w_start) begin
        r_cpol <= cpol_i;
        r_cpha <= cpha_i;
        r_n    <= '0;
        r_rx   <= '0;
      end
      if (w_stop) begin
        r_n  <= '0;
        r_rx <= '0;
      end
      if (w_sample) begin
        r_rx <= {r_rx[6:0], r_mosi_sync[1]};
        r_n  <= r_n + 3'd1;
        if (r_n == 3'd7) begin
          r_dout <= {r_rx[6:0], r_mosi_sync[1]};
          r_done <= 1'b1;
        end
      end
      if (w_load) begin
        r_tx    <= r_full ? r_buf : 8'h00;
        r_under <= ~r_full;
      end else if (w_shift) begin
        r_tx <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // a host write in the same cycle as a shifter load wins the flag; the shifter takes the old byte
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf  <= '0;
      r_full <= 1'b0;
    end else if (tx_load_i) begin
      r_buf  <= tx_data_i;
      r_full <= 1'b1;
    end else if (w_load) begin
      r_full <= 1'b0;
    end
  end

  assign tx_ready_o      = ~r_full;
  assign dout_o          = r_dout;
  assign spi_done_tick_o = r_done;
  assign underrun_tick_o = r_under;
  assign busy_o          = (r_state == ST_ACTIVE);
  assign miso_o          = (r_state == ST_ACTIVE) & r_tx[7];

endmodule
